// File: rtl/alu_defs.sv
`default_nettype none
// ============================================================================
// Module      : alu_defs (package)
// Description : Opcode encodings, FSM state encodings and flag bundle for alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_defs;

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_NOT  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NEGA = 4'b0110;
    localparam logic [3:0] OP_NEGB = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_ADC  = 4'b1001;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Unsigned shift-add multiplier, one partial product per step.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_last,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_product
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_sum;

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign w_sum     = r_acc + w_addend;
    // The final product is taken from the adder during the last step, so the
    // caller can register it on the same edge that completes the multiply.
    assign o_product = w_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (i_step) begin
            if (i_last) begin
                r_mcand  <= '0;
                r_mplier <= '0;
                r_acc    <= '0;
            end else begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with flags, add-with-carry and a multi-cycle
//               multiplier behind a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_defs::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_alu,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_cnt_w-1:0]  r_count;
    logic                w_is_mul;
    logic                w_last;
    logic                w_busy;
    logic                w_mul_load;
    logic                w_mul_step;
    logic                w_wr_alu;
    logic                w_wr_mul;

    logic [WIDTH:0]      w_ext;
    logic                w_add_ovf;
    logic                w_sub_ovf;
    logic [WIDTH-1:0]    w_alu_y;
    logic                w_alu_c;
    logic                w_alu_v;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_res_y;
    logic                w_res_c;
    logic                w_res_v;

    logic [WIDTH-1:0]    r_y;
    alu_flags_t          r_flags;
    logic                r_done;

    assign w_is_mul = MUL_EN && (op_alu == OP_MUL);
    assign w_last   = (r_count == c_last_step);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start && w_is_mul) w_state_next = ST_MUL;
            ST_MUL:  if (w_last)            w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // start is only looked at in IDLE, so requests during a multiply drop.
    always_comb begin
        w_busy     = 1'b0;
        w_mul_load = 1'b0;
        w_mul_step = 1'b0;
        w_wr_alu   = 1'b0;
        w_wr_mul   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_alu   = start && !w_is_mul;
                w_mul_load = start && w_is_mul;
            end
            ST_MUL: begin
                w_busy     = 1'b1;
                w_mul_step = 1'b1;
                w_wr_mul   = w_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_mul_load) begin
            r_count <= '0;
        end else if (w_mul_step) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk       (clk),
                .reset     (reset),
                .i_load    (w_mul_load),
                .i_step    (w_mul_step),
                .i_last    (w_last),
                .i_a       (a),
                .i_b       (b),
                .o_product (w_prod)
            );
        end else begin : g_no_mul
            assign w_prod = '0;
        end
    endgenerate

    // Single-cycle datapath; w_ext[WIDTH] carries carry-out or borrow.
    always_comb begin
        w_ext     = '0;
        w_add_ovf = 1'b0;
        w_sub_ovf = 1'b0;
        case (op_alu)
            OP_PASS: w_ext = {1'b0, a};
            OP_NOT:  w_ext = {1'b0, ~a};
            OP_ADD: begin
                w_ext     = {1'b0, a} + {1'b0, b};
                w_add_ovf = 1'b1;
            end
            OP_SUB: begin
                w_ext     = {1'b0, a} - {1'b0, b};
                w_sub_ovf = 1'b1;
            end
            OP_AND:  w_ext = {1'b0, a & b};
            OP_OR:   w_ext = {1'b0, a | b};
            OP_NEGA: w_ext = {1'b0, -a};
            OP_NEGB: w_ext = {1'b0, -b};
            OP_ADC: begin
                w_ext     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, r_flags.carry};
                w_add_ovf = 1'b1;
            end
            default: w_ext = {1'b0, a};
        endcase
    end

    assign w_alu_y = w_ext[WIDTH-1:0];
    assign w_alu_c = w_ext[WIDTH];
    assign w_alu_v = (w_add_ovf && (a[WIDTH-1] == b[WIDTH-1]) && (w_alu_y[WIDTH-1] != a[WIDTH-1]))
                  || (w_sub_ovf && (a[WIDTH-1] != b[WIDTH-1]) && (w_alu_y[WIDTH-1] != a[WIDTH-1]));

    assign w_res_y = w_wr_mul ? w_prod[WIDTH-1:0]        : w_alu_y;
    assign w_res_c = w_wr_mul ? |w_prod[2*WIDTH-1:WIDTH] : w_alu_c;
    assign w_res_v = w_wr_mul ? 1'b0                     : w_alu_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y              <= '0;
            r_flags.zero     <= 1'b1;
            r_flags.carry    <= 1'b0;
            r_flags.negative <= 1'b0;
            r_flags.overflow <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_done <= w_wr_alu || w_wr_mul;
            if (w_wr_alu || w_wr_mul) begin
                r_y              <= w_res_y;
                r_flags.zero     <= (w_res_y == '0);
                r_flags.carry    <= w_res_c;
                r_flags.negative <= w_res_y[WIDTH-1];
                r_flags.overflow <= w_res_v;
            end
        end
    end

    assign busy     = w_busy;
    assign done     = r_done;
    assign y        = r_y;
    assign zero     = r_flags.zero;
    assign carry    = r_flags.carry;
    assign negative = r_flags.negative;
    assign overflow = r_flags.overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed and randomized checks of alu_seq against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    op_alu = '0;
    logic          busy, done, zero, carry, negative, overflow;
    logic [W-1:0]  y;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .op_alu   (op_alu),
        .busy     (busy),
        .done     (done),
        .y        (y),
        .zero     (zero),
        .carry    (carry),
        .negative (negative),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic in wide signed/unsigned integers.
    function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic cin, output logic [W-1:0] ry, output logic rc,
                                   output logic rv);
        longint ua, ub, r, sa, sb, s;
        ua = ia; ub = ib; sa = $signed(ia); sb = $signed(ib);
        rc = 1'b0; rv = 1'b0; r = ua;
        case (op)
            4'd0: r = ua;
            4'd1: r = 65535 - ua;
            4'd2: begin r = ua + ub; rc = (r > 65535); s = sa + sb; rv = (s > 32767) || (s < -32768); end
            4'd3: begin r = ua - ub + 65536; rc = (ua < ub); s = sa - sb; rv = (s > 32767) || (s < -32768); end
            4'd4: r = longint'(ia & ib);
            4'd5: r = longint'(ia | ib);
            4'd6: r = 65536 - ua;
            4'd7: r = 65536 - ub;
            4'd8: begin r = ua * ub; rc = (r > 65535); end
            4'd9: begin
                r = ua + ub + longint'(cin); rc = (r > 65535);
                s = sa + sb + longint'(cin); rv = (s > 32767) || (s < -32768);
            end
            default: r = ua;
        endcase
        ry = r[W-1:0];
    endfunction

    logic [W-1:0] m_y = '0;
    logic         m_z = 1'b1, m_c = 1'b0, m_n = 1'b0, m_v = 1'b0, m_done = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] p_y = '0;
    logic         p_c = 1'b0;
    logic [W-1:0] t_y;
    logic         t_c, t_v;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_y = '0; m_z = 1'b1; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
            m_done = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_y = p_y; m_c = p_c; m_v = 1'b0; m_z = (p_y == 0); m_n = p_y[W-1];
                    m_done = 1'b1;
                end
            end else if (start === 1'b1) begin
                ref_op(op_alu, a, b, m_c, t_y, t_c, t_v);
                if (op_alu == 4'd8) begin
                    p_y = t_y; p_c = t_c; m_cnt = W;
                end else begin
                    m_y = t_y; m_c = t_c; m_v = t_v; m_z = (t_y == 0); m_n = t_y[W-1];
                    m_done = 1'b1;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        chk("cyc_done", done, m_done);
        chk("cyc_busy", busy, m_cnt > 0);
        chk("cyc_y", y, m_y);
        chk("cyc_flags", {zero, carry, negative, overflow}, {m_z, m_c, m_n, m_v});
    end

    // Drive a request at a negedge and return at the negedge where done shows.
    task automatic run(input logic [3:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib, output int lat);
        start = 1'b1; op_alu = op; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int lat;
    int k;
    int ndone;
    logic [W-1:0] pick [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_y", y, 16'h0000);
        chk("rst_flags", {zero, carry, negative, overflow}, 4'b1000);
        chk("rst_busy_done", {busy, done}, 2'b00);
        reset = 1'b0;
        @(negedge clk);

        run(4'd2, 16'hFFFF, 16'h0001, lat);
        chk("add_lat", lat, 1);
        chk("add_y", y, 16'h0000);
        chk("add_zcnv", {zero, carry, negative, overflow}, 4'b1100);
        run(4'd9, 16'h0001, 16'h0001, lat);
        chk("adc_y", y, 16'h0003);
        chk("adc_c", carry, 1'b0);
        run(4'd3, 16'h0003, 16'h0005, lat);
        chk("sub_y", y, 16'hFFFE);
        chk("sub_zcnv", {zero, carry, negative, overflow}, 4'b0110);
        run(4'd2, 16'h7FFF, 16'h0001, lat);
        chk("ovf_y", y, 16'h8000);
        chk("ovf_zcnv", {zero, carry, negative, overflow}, 4'b0011);

        run(4'd8, 16'h0123, 16'h0004, lat);
        chk("mul_lat", lat, 17);
        chk("mul_y", y, 16'h048C);
        chk("mul_c", carry, 1'b0);
        run(4'd8, 16'h1000, 16'h0010, lat);
        chk("mulhi_y", y, 16'h0000);
        chk("mulhi_zc", {zero, carry}, 2'b11);

        // A start during busy must be dropped and leave timing unchanged.
        start = 1'b1; op_alu = 4'd8; a = 16'h0123; b = 16'h0004;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            start = (k == 3);
            if (k == 3) begin op_alu = 4'd2; a = 16'h0001; b = 16'h0001; end
            if (k == 5) chk("busy_hold_y", y, 16'h0000);
        end while (!done && k < 40);
        start = 1'b0;
        chk("busy_lat", k, 17);
        chk("busy_y", y, 16'h048C);
        @(negedge clk);
        chk("busy_nodone", done, 1'b0);

        start = 1'b1; op_alu = 4'd4; a = 16'hF0F0; b = 16'h0FF0;
        @(negedge clk);
        chk("b2b_and", {done, y, zero}, {1'b1, 16'h00F0, 1'b0});
        op_alu = 4'd5; a = 16'h00F0; b = 16'h0F00;
        @(negedge clk);
        chk("b2b_or", {done, y, zero}, {1'b1, 16'h0FF0, 1'b0});
        op_alu = 4'd6; a = 16'h0001;
        @(negedge clk);
        chk("b2b_nega", {done, y, zero}, {1'b1, 16'hFFFF, 1'b0});
        op_alu = 4'd7; b = 16'h0000;
        @(negedge clk);
        chk("b2b_negb", {done, y, zero}, {1'b1, 16'h0000, 1'b1});
        start = 1'b0;

        // Reset partway through a multiply aborts it.
        start = 1'b1; op_alu = 4'd8; a = 16'h0003; b = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_state", {busy, done, y, zero, carry, negative, overflow}, {2'b00, 16'h0000, 4'b1000});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mrst_nodone", ndone, 0);
        run(4'd2, 16'h0001, 16'h0001, lat);
        chk("mrst_add_y", y, 16'h0002);

        for (int i = 0; i < 1500; i++) begin
            start  = ($urandom_range(0, 9) < 7);
            op_alu = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                start = 1'b0;
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
